// File: rtl/keypad_matrix_emulator.sv
// Column-side emulator of a 4x4 keypad matrix: queued synthetic key presses are
// replayed as bounce / clean hold / release gap on the scanner's kp_row/kp_col wires.
module keypad_matrix_emulator #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 8,
    parameter int BOUNCE_CYC = 3,
    parameter int GAP_CYC    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        kp_row,
    output logic [3:0]        kp_col,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic              busy,
    output logic              key_down,
    output logic              cmd_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(BOUNCE_CYC + GAP_CYC + 2);

    typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD, S_GAP} state_t;

    state_t            state_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [3:0]        row_mem [FIFO_DEPTH];
    logic [3:0]        col_mem [FIFO_DEPTH];
    logic [HOLD_W-1:0] hold_mem [FIFO_DEPTH];
    logic [3:0]        cur_row_q, cur_col_q;
    logic [HOLD_W-1:0] hold_cnt_q, hold_eff;
    logic [CW-1:0]     cnt_q;
    logic              bph_q, key_down_q, cmd_err_q;
    logic              key_ok, full, accept, push, pop;
    logic [3:0]        key_row, key_col;

    always_comb begin
        key_ok  = 1'b1;
        key_row = 4'b1101;
        key_col = 4'b1110;
        case (cmd_key)
            4'h8: key_col = 4'b1110;
            4'h5: key_col = 4'b1101;
            4'h2: key_col = 4'b1011;
            4'hA: key_col = 4'b0111;
            4'h7: begin key_row = 4'b1110; key_col = 4'b1110; end
            4'h4: begin key_row = 4'b1110; key_col = 4'b1101; end
            4'h1: begin key_row = 4'b1110; key_col = 4'b1011; end
            4'h0: begin key_row = 4'b1110; key_col = 4'b0111; end
            default: key_ok = 1'b0;
        endcase
    end

    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign accept    = cmd_valid && cmd_ready && !abort;
    assign push      = accept && key_ok;
    assign pop       = (state_q == S_IDLE) && (count_q != '0) && !abort;
    assign hold_eff  = (hold_mem[rd_ptr_q] == '0) ? HOLD_W'(1) : hold_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Queue storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            row_mem[wr_ptr_q]  <= key_row;
            col_mem[wr_ptr_q]  <= key_col;
            hold_mem[wr_ptr_q] <= cmd_hold;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_row_q  <= '1;
            cur_col_q  <= '1;
            hold_cnt_q <= '0;
            cnt_q      <= '0;
            bph_q      <= 1'b0;
            key_down_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            cmd_err_q <= accept && !key_ok;
            if (abort) begin
                state_q    <= S_IDLE;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                key_down_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
                // key_down_q is the value emitted by the current state, so the
                // pop clock itself is a released load cycle before first contact.
                case (state_q)
                    S_IDLE: begin
                        key_down_q <= 1'b0;
                        if (pop) begin
                            cur_row_q  <= row_mem[rd_ptr_q];
                            cur_col_q  <= col_mem[rd_ptr_q];
                            hold_cnt_q <= hold_eff;
                            bph_q      <= 1'b1;
                            cnt_q      <= CW'(BOUNCE_CYC);
                            state_q    <= (BOUNCE_CYC == 0) ? S_HOLD : S_BOUNCE;
                        end
                    end
                    S_BOUNCE: begin
                        key_down_q <= bph_q;
                        bph_q      <= !bph_q;
                        if (cnt_q <= CW'(1)) state_q <= S_HOLD;
                        else                 cnt_q   <= cnt_q - 1'b1;
                    end
                    S_HOLD: begin
                        key_down_q <= 1'b1;
                        if (hold_cnt_q <= HOLD_W'(1)) begin
                            state_q <= S_GAP;
                            cnt_q   <= CW'(GAP_CYC);
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        key_down_q <= 1'b0;
                        if (cnt_q <= CW'(1)) state_q <= S_IDLE;
                        else                 cnt_q   <= cnt_q - 1'b1;
                    end
                endcase
            end
        end
    end

    assign kp_col   = (key_down_q && (kp_row == cur_row_q)) ? cur_col_q : 4'b1111;
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign key_down = key_down_q;
    assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: issued presses queue their expected
// row/column and contact-clock count; a negedge monitor checks each replayed press.
module tb_keypad_matrix_emulator;
    localparam int BC = 3;
    localparam int GC = 2;
    localparam int BOUNCE_ONES = (BC + 1) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] kp_row = 4'b1101;
    logic [3:0] kp_col;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_key = 4'h0;
    logic [7:0] cmd_hold = 8'd0;
    logic       abort = 1'b0;
    logic       busy, key_down, cmd_err;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        int         ones;
        bit         chk;
    } press_t;

    press_t press_q[$];
    int     err_exp = 0;
    int     total = 0;
    int     bad = 0;

    keypad_matrix_emulator #(
        .FIFO_DEPTH(4), .HOLD_W(8), .BOUNCE_CYC(BC), .GAP_CYC(GC)
    ) dut (
        .clk(clk), .rst(rst), .kp_row(kp_row), .kp_col(kp_col),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_hold(cmd_hold), .abort(abort), .busy(busy),
        .key_down(key_down), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Scanner: alternates between the two populated rows every clock.
    initial forever begin
        @(posedge clk);
        #1 kp_row = (kp_row == 4'b1101) ? 4'b1110 : 4'b1101;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_key(input logic [3:0] k, output logic [3:0] r,
                             output logic [3:0] c, output bit ok);
        ok = 1'b1; r = 4'b1101; c = 4'b1111;
        case (k)
            4'h8: c = 4'b1110;
            4'h5: c = 4'b1101;
            4'h2: c = 4'b1011;
            4'hA: c = 4'b0111;
            4'h7: begin r = 4'b1110; c = 4'b1110; end
            4'h4: begin r = 4'b1110; c = 4'b1101; end
            4'h1: begin r = 4'b1110; c = 4'b1011; end
            4'h0: begin r = 4'b1110; c = 4'b0111; end
            default: ok = 1'b0;
        endcase
    endtask

    task automatic send(input logic [3:0] key, input int hold);
        logic [3:0] r, c;
        bit ok, rdy;
        press_t p;
        cmd_valid = 1'b1; cmd_key = key; cmd_hold = 8'(hold);
        rdy = cmd_ready;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (rdy) begin
            model_key(key, r, c, ok);
            if (ok) begin
                p.row = r; p.col = c; p.chk = 1'b1;
                p.ones = ((hold == 0) ? 1 : hold) + BOUNCE_ONES;
                press_q.push_back(p);
            end else begin
                err_exp++;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_kd();
        int n;
        for (n = 0; n < 50 && !key_down; n++) tick(1);
        check("wait_contact", key_down, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 400 && busy; n++) tick(1);
        check("idle_reached", busy, 1'b0);
        tick(4);
    endtask

    // Monitor: every negedge, compares column drive and closes out finished presses.
    initial begin
        bit in_press = 1'b0;
        int ones = 0;
        int zeros = 0;
        logic [3:0] exp_col;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_press = 1'b0;
                continue;
            end
            if (cmd_err) begin
                check("cmd_err_expected", 32'(err_exp > 0), 1);
                if (err_exp > 0) err_exp--;
            end
            if (!in_press && key_down) begin
                if (press_q.size() == 0) check("unexpected_press", press_q.size(), 1);
                else begin in_press = 1'b1; ones = 0; zeros = 0; end
            end
            if (in_press) begin
                exp_col = (key_down && kp_row == press_q[0].row) ? press_q[0].col : 4'hF;
                check("kp_col", kp_col, exp_col);
                if (key_down) begin ones++; zeros = 0; end
                else zeros++;
                if (zeros == 2) begin
                    if (press_q[0].chk) check("contact_clocks", ones, press_q[0].ones);
                    void'(press_q.pop_front());
                    in_press = 1'b0;
                end
            end else begin
                check("kp_col_idle", kp_col, 4'hF);
            end
        end
    end

    initial begin
        logic [8:0] pat;
        // Reset with scanner running
        tick(3);
        check("rst_kp_col", kp_col, 4'hF);
        check("rst_busy", busy, 1'b0);
        check("rst_key_down", key_down, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        rst = 1'b0;
        tick(1);
        check("rst_cmd_ready", cmd_ready, 1'b1);

        // Single press of A, 5 clean clocks
        send(4'hA, 5);
        wait_idle();

        // Exact bounce/hold/gap timing for key 7, hold 4
        send(4'h7, 4);
        tick(1);
        pat = 9'b101111100;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            check("kd_pattern", key_down, pat[8-i]);
        end
        tick(1);
        check("busy_after_pattern", busy, 1'b0);
        wait_idle();

        // Queue full while a long press plays
        send(4'h5, 10);
        wait_kd();
        send(4'h8, 3);
        send(4'h0, 3);
        send(4'h7, 3);
        send(4'hA, 3);
        check("full_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        cmd_valid = 1'b1; cmd_key = 4'h1; cmd_hold = 8'd3;
        tick(1);
        check("full_ready_hold", cmd_ready, 1'b0);
        tick(1);
        cmd_valid = 1'b0;
        wait_idle();

        // Abort mid-HOLD with two commands queued, plus one offered in the abort clock
        send(4'h2, 8);
        wait_kd();
        send(4'h4, 2);
        send(4'h1, 2);
        tick(4);
        check("pre_abort_kd", key_down, 1'b1);
        abort = 1'b1;
        cmd_valid = 1'b1; cmd_key = 4'h8; cmd_hold = 8'd2;
        check("abort_ready", cmd_ready, 1'b1);
        tick(1);
        abort = 1'b0; cmd_valid = 1'b0;
        press_q[0].chk = 1'b0;
        while (press_q.size() > 1) void'(press_q.pop_back());
        check("abort_kp_col", kp_col, 4'hF);
        check("abort_busy", busy, 1'b0);
        check("abort_kd", key_down, 1'b0);
        check("abort_ready_after", cmd_ready, 1'b1);
        tick(30);
        check("abort_quiet_busy", busy, 1'b0);

        // Unsupported key, then a zero-hold command
        check("bad_key_ready", cmd_ready, 1'b1);
        send(4'h3, 5);
        check("bad_key_busy", busy, 1'b0);
        tick(6);
        check("bad_key_kd", key_down, 1'b0);
        check("bad_key_busy_later", busy, 1'b0);
        send(4'h1, 0);
        wait_idle();

        check("scoreboard_empty", press_q.size(), 0);
        check("err_consumed", err_exp, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
